// File: rtl/onehot_decode_queue_if.sv
// Stream bundle for onehot_decode_queue: index input side and one-hot output side.
// master = producer/consumer environment, slave = the queue.
interface onehot_decode_queue_if #(
    parameter int IN_WIDTH = 4
);
    localparam int OW = 2 ** IN_WIDTH;

    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_index;
    logic                in_enable;
    logic                out_valid;
    logic                out_ready;
    logic [OW-1:0]       out_onehot;
    logic [IN_WIDTH-1:0] out_index;

    modport master (
        output in_valid, in_index, in_enable, out_ready,
        input  in_ready, out_valid, out_onehot, out_index
    );

    modport slave (
        input  in_valid, in_index, in_enable, out_ready,
        output in_ready, out_valid, out_onehot, out_index
    );
endinterface

// File: rtl/onehot_decode_queue.sv
// Buffered binary-index to one-hot decoder: DEPTH-entry FIFO of {enable, index}
// whose head entry drives a one-hot vector behind a valid/ready handshake.
module onehot_decode_queue #(
    parameter int IN_WIDTH = 4,
    parameter int DEPTH    = 4,
    localparam int OW      = 2 ** IN_WIDTH,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    onehot_decode_queue_if.slave     bus,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic                en;
        logic [IN_WIDTH-1:0] idx;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          push;
    logic          pop;
    entry_t        head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    assign head = mem[rp];

    // Outputs depend only on registered state, never on in_* or out_ready.
    always_comb begin
        bus.out_onehot = '0;
        bus.out_index  = '0;
        if (!empty) begin
            bus.out_index = head.idx;
            if (head.en) begin
                bus.out_onehot = OW'(1) << head.idx;
            end
        end
    end

    // Storage carries no reset; stale slots are masked by the empty check.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wp] <= '{en: bus.in_enable, idx: bus.in_index};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
            end
            if (pop) begin
                rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
            end
            unique case (1'b1)
                push && !pop: count <= count + CW'(1);
                pop && !push: count <= count - CW'(1);
                default:      count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_onehot_decode_queue.sv
// Scoreboard bench for onehot_decode_queue: accepted pushes queue their expected
// one-hot word; a negedge monitor checks each presented head against the queue.
module tb_onehot_decode_queue;
    localparam int IW = 4;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          CLK;
    logic          RESET_N;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    onehot_decode_queue_if #(.IN_WIDTH(IW)) bus ();

    onehot_decode_queue #(.IN_WIDTH(IW), .DEPTH(DP)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    typedef struct packed {
        logic [15:0]   onehot;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] cur_exp;
    int          checks = 0;
    int          errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [IW-1:0] enc16(input logic [15:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record what the producer handed over on each accepting edge.
    always @(posedge CLK) begin
        if (RESET_N && bus.in_valid && bus.in_ready) begin
            sb.push_back('{onehot: cur_exp, idx: bus.in_index});
        end
    end

    always @(negedge CLK) begin
        if (RESET_N) begin
            check("valid_vs_model", 32'(bus.out_valid), 32'(sb.size() != 0));
            if (!bus.out_valid) begin
                check("idle_onehot", 32'(bus.out_onehot), 32'h0);
                check("idle_index", 32'(bus.out_index), 32'h0);
            end else if (bus.out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("head_onehot", 32'(bus.out_onehot), 32'(e.onehot));
                check("head_index", 32'(bus.out_index), 32'(e.idx));
                if (e.onehot != 16'h0) begin
                    check("round_trip", 32'(enc16(bus.out_onehot)), 32'(e.idx));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] idx,
                         input logic en, input logic [15:0] exp);
        bus.in_valid  = v;
        bus.in_index  = idx;
        bus.in_enable = en;
        cur_exp       = exp;
    endtask

    task automatic push1(input logic [IW-1:0] idx, input logic [15:0] exp);
        drive(1'b1, idx, 1'b1, exp);
        cyc();
        drive(1'b0, '0, 1'b0, 16'h0);
    endtask

    initial begin
        RESET_N       = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, 1'b0, 16'h0);
        #3;
        check("rst_count", 32'(count), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_onehot", 32'(bus.out_onehot), 32'h0);
        #9 RESET_N = 1'b1;
        cyc();

        // Decode sweep, one push per cycle with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, IW'(i), 1'b1, 16'h0001 << i);
            cyc();
            check("sweep_count", 32'(count), 32'h1);
        end
        drive(1'b0, '0, 1'b0, 16'h0);
        cyc();
        check("sweep_empty", 32'(empty), 32'h1);

        // Disabled entry decodes to zero but still echoes its index.
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd7, 1'b0, 16'h0000);
        cyc();
        drive(1'b0, '0, 1'b0, 16'h0);
        check("dis_valid", 32'(bus.out_valid), 32'h1);
        check("dis_onehot", 32'(bus.out_onehot), 32'h0);
        check("dis_index", 32'(bus.out_index), 32'h7);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        check("dis_drained", 32'(empty), 32'h1);

        // Fill and backpressure.
        push1(4'd3, 16'h0008);
        check("fill_c1", 32'(count), 32'h1);
        push1(4'd5, 16'h0020);
        check("fill_c2", 32'(count), 32'h2);
        push1(4'd9, 16'h0200);
        check("fill_c3", 32'(count), 32'h3);
        push1(4'd12, 16'h1000);
        check("fill_c4", 32'(count), 32'h4);
        check("fill_full", 32'(full), 32'h1);
        check("fill_in_ready", 32'(bus.in_ready), 32'h0);
        push1(4'd6, 16'h0040);
        check("fill_reject", 32'(count), 32'h4);
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        bus.out_ready = 1'b0;
        check("fill_drained", 32'(empty), 32'h1);

        // Full with simultaneous push attempt and pop.
        push1(4'd2, 16'h0004);
        push1(4'd4, 16'h0010);
        push1(4'd6, 16'h0040);
        push1(4'd8, 16'h0100);
        check("fp_full", 32'(full), 32'h1);
        drive(1'b1, 4'd10, 1'b1, 16'h0400);
        bus.out_ready = 1'b1;
        cyc();
        check("fp_pop_only", 32'(count), 32'h3);
        check("fp_in_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b0;
        cyc();
        drive(1'b0, '0, 1'b0, 16'h0);
        check("fp_accepted", 32'(count), 32'h4);
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        bus.out_ready = 1'b0;
        check("fp_drained", 32'(empty), 32'h1);

        // Continuous push+pop at occupancy 2 drives both pointers past the wrap.
        push1(4'd1, 16'h0002);
        push1(4'd14, 16'h4000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, IW'(15 - i), 1'b1, 16'h8000 >> i);
            cyc();
            check("wrap_count", 32'(count), 32'h2);
        end
        drive(1'b0, '0, 1'b0, 16'h0);
        repeat (2) cyc();
        bus.out_ready = 1'b0;
        check("wrap_drained", 32'(empty), 32'h1);

        // Asynchronous reset in the middle of a cycle with three entries held.
        push1(4'd11, 16'h0800);
        push1(4'd13, 16'h2000);
        push1(4'd0, 16'h0001);
        check("mr_count3", 32'(count), 32'h3);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        sb.delete();
        #1;
        check("mr_count", 32'(count), 32'h0);
        check("mr_empty", 32'(empty), 32'h1);
        check("mr_out_valid", 32'(bus.out_valid), 32'h0);
        check("mr_onehot", 32'(bus.out_onehot), 32'h0);
        check("mr_in_ready", 32'(bus.in_ready), 32'h1);
        #1 RESET_N = 1'b1;
        cyc();
        push1(4'd1, 16'h0002);
        check("mr_post_onehot", 32'(bus.out_onehot), 32'h0002);
        bus.out_ready = 1'b1;

        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
        check("sb_empty_at_end", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_decode_queue.md
Name: onehot_decode_queue

Overview:
- Inverse of the Encoder_16/8/4 family: converts binary indices back into one-hot vectors.
- Adds a small buffered valid/ready stream stage so a producer (decode/writeback) is decoupled from a consumer (register-file write enables, bypass select).
- Indices enter through a DEPTH-entry FIFO. The head entry is decoded to a 2**IN_WIDTH-bit one-hot output with its own valid/ready handshake.

Parameters:
- IN_WIDTH, 4, index width; output width is 2**IN_WIDTH (16 by default).
- DEPTH, 4, FIFO entries; any value >= 2, not required to be a power of two.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an entry.
- in_ready  output  1  queue can accept; equals !full.
- in_index  input  IN_WIDTH  index to decode.
- in_enable  input  1  0 = entry decodes to all-zero vector (no bit set).
- out_valid  output  1  head entry present; equals !empty.
- out_ready  input  1  consumer takes the head entry.
- out_onehot  output  2**IN_WIDTH  decoded head: bit[index] = enable; all other bits 0.
- out_index  output  IN_WIDTH  raw head index (echo for debug/bypass).
- count  output  clog2(DEPTH+1)  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage:
  - DEPTH entries of {enable, index}.
  - Write pointer wp, read pointer rp, occupancy count.
  - Each pointer wraps to 0 after reaching DEPTH-1, with an explicit compare and no reliance on power-of-two overflow.
- Push: in_valid && in_ready at a rising edge. Writes the entry at wp, then wp advances.
- Pop: out_valid && out_ready at a rising edge. rp advances.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Output path:
  - out_onehot and out_index are combinational functions of the registered head entry only.
  - No combinational path from in_* to out_*.
  - No combinational path from out_ready to in_ready.
- Latency: an entry pushed at edge N is visible on out_* (out_valid=1) after edge N, i.e. one cycle. There is no same-cycle bypass when empty.
- Empty boundary:
  - out_valid=0.
  - out_onehot forced to all-zero and out_index to 0, regardless of stale storage.
  - out_ready is ignored, and count never underflows.
- Full boundary:
  - in_ready=0, so a push is impossible even if a pop occurs in the same cycle.
  - The pop frees a slot; in_ready rises the next cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both occur, count holds, pointers each advance and wrap independently.
- Decode rules:
  - enable=1: exactly one bit set, at position index.
  - enable=0: all zeros.
  - All indices 0..2**IN_WIDTH-1 are legal; no out-of-range case exists.
- Reset (RESET_N low, asynchronous, any time including mid-transfer):
  - wp, rp, count cleared to 0 immediately.
  - Immediate output values: empty=1, full=0, in_ready=1, out_valid=0, out_onehot=0, out_index=0.
  - Storage contents need not be cleared.
  - In-flight entries are discarded.
  - The first edge after RESET_N deasserts behaves as a normal edge.
- Round trip: for enable=1 entries, feeding out_onehot into Encoder_16 yields in_index. The bench uses this as a self-check.

Test Plan:
- Basic decode sweep:
  - Stimulus: out_ready=1; push index 0..15 with enable=1, one per cycle.
  - Required: out_onehot=16'h0001, 16'h0002, ... 16'h8000, each one cycle after its push.
  - Required: Encoder_16(out_onehot)==index; count stays <=1.
- Disabled entry:
  - Stimulus: push {enable=0, index=7}.
  - Required: out_valid=1, out_onehot=16'h0000, out_index=7.
- Fill and backpressure:
  - Stimulus: out_ready=0; push indices 3, 5, 9, 12.
  - Required: count 1,2,3,4; full=1 and in_ready=0 after the 4th push; a 5th in_valid is not accepted.
  - Then out_ready=1: required outputs in order 16'h0008, 16'h0020, 16'h0200, 16'h1000, then empty=1.
- Full with simultaneous pop:
  - Stimulus: queue full, in_valid=1 and out_ready=1 on the same edge.
  - Required: pop only, count 4->3; in_ready=1 next cycle; pushed word is not lost (accepted on the next edge).
- Wrap-around:
  - Stimulus: 10 cycles of continuous push+pop with count held at 2.
  - Required: pointers wrap past DEPTH-1 and the output sequence exactly matches the input order.
- Reset mid-operation:
  - Stimulus: count=3, assert RESET_N=0 between edges.
  - Required: immediately count=0, empty=1, out_valid=0, out_onehot=0.
  - After release, push index 1: out_onehot=16'h0002 one cycle later.
